// File: rtl/sym_fifo_sched_pkg.sv
// Shared types and helpers for the read-side scheduler of the symmetric dual-clock FIFOs.
// The queue entry widths are fixed here and must match the scheduler's DATA_WIDTH/CH_WIDTH.
package sym_fifo_sched_pkg;

  localparam int SCHED_DATA_WIDTH = 64;
  localparam int SCHED_CH_WIDTH   = 2;
  localparam int MAX_CH           = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_DATA_WIDTH-1:0] data;
    logic [SCHED_CH_WIDTH-1:0]   ch;
    logic                        last;
  } q_entry_t;

  // Ceiling log2, never less than 1 so single-entry ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // First set bit of req searching upward from ptr+1, wrapping modulo n.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i <= n) && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sched_out_queue.sv
// Synchronous show-ahead queue holding returned FIFO words until the stream consumer takes them.
module sched_out_queue
  import sym_fifo_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  q_entry_t         push_entry,
  input  logic             pop,
  output q_entry_t         head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int AW = clog2(DEPTH);

  q_entry_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;

  assign do_pop = pop && (count != '0);

  // NOTE: storage has no reset; validity is tracked by count, so only the pointers need one.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sym_fifo_rd_sched.sv
// Round-robin read scheduler over NUM_CH dual-clock FIFOs: bursts reads from one granted FIFO
// at a time and streams the words out through a credit-limited show-ahead queue.
module sym_fifo_rd_sched
  import sym_fifo_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = SCHED_DATA_WIDTH,
  parameter int BURST_LEN  = 16,
  parameter int CH_WIDTH   = SCHED_CH_WIDTH,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                         clk_rd,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH-1:0]            fifo_empty,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
  input  logic [NUM_CH-1:0]            fifo_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_WIDTH-1:0]          m_ch,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         burst_done
);

  localparam int CNT_W  = clog2(BURST_LEN + 1);
  localparam int QCNT_W = clog2(OBUF_DEPTH + 1);

  sched_state_t          state;
  logic [CH_WIDTH-1:0]   rr_ptr;
  logic [CH_WIDTH-1:0]   sel;
  logic [CH_WIDTH-1:0]   pick;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      ret_cnt;
  logic                  inflight;
  logic [NUM_CH-1:0]     req;
  logic [QCNT_W-1:0]     q_count;
  logic [QCNT_W:0]       credit_used;
  logic                  q_full;
  logic                  issue;
  logic                  q_push;
  logic                  ret_last;
  q_entry_t              push_entry;
  q_entry_t              head;

  assign req  = ch_mask & ~fifo_empty;
  assign pick = CH_WIDTH'(rr_pick(MAX_CH'(req), 32'(rr_ptr), NUM_CH));

  // A word read last cycle is still on its way, so it already holds a queue slot.
  assign credit_used = {1'b0, q_count} + {{QCNT_W{1'b0}}, inflight};

  assign issue = (state == ST_BURST) && !fifo_empty[sel] &&
                 (issue_cnt < CNT_W'(BURST_LEN)) &&
                 (credit_used < (QCNT_W+1)'(OBUF_DEPTH));

  assign fifo_rd_en = issue ? (NUM_CH'(1) << sel) : '0;

  // The FIFO's empty flag already reflects last cycle's read, so it marks a short burst exactly.
  assign q_push     = (state == ST_BURST) && fifo_valid[sel];
  assign ret_last   = ((ret_cnt + CNT_W'(1)) == CNT_W'(BURST_LEN)) || fifo_empty[sel];
  assign burst_done = q_push && ret_last;

  assign push_entry = '{data: fifo_dout[32'(sel)*DATA_WIDTH +: DATA_WIDTH],
                        ch:   sel,
                        last: ret_last};

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= CH_WIDTH'(NUM_CH - 1);
      sel       <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_ARB;
        end
        ST_ARB: begin
          if (|req) begin
            sel       <= pick;
            rr_ptr    <= pick;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= ST_BURST;
          end else if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (issue)      issue_cnt <= issue_cnt + 1'b1;
          if (q_push)     ret_cnt   <= ret_cnt + 1'b1;
          if (burst_done) state     <= ST_WAIT;
        end
        ST_WAIT: begin
          state <= enable ? ST_ARB : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sched_out_queue #(
    .DEPTH (OBUF_DEPTH),
    .CNT_W (QCNT_W)
  ) u_queue (
    .clk        (clk_rd),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (m_valid && m_ready),
    .head       (head),
    .count      (q_count),
    .full       (q_full)
  );

  assign m_valid = (q_count != '0);
  assign m_data  = m_valid ? head.data : '0;
  assign m_ch    = m_valid ? head.ch   : '0;
  assign m_last  = m_valid ? head.last : 1'b0;
  assign busy    = (state != ST_IDLE) || m_valid;

  a_no_overflow: assert property (@(posedge clk_rd) disable iff (!rst_n) !(q_push && q_full));

endmodule

// File: tb/tb_sym_fifo_rd_sched.sv
// Bench for sym_fifo_rd_sched: behavioural latency-1 FIFO models feed the scheduler and a
// scoreboard of expected {data, ch, last} words is compared against the output stream.
module tb_sym_fifo_rd_sched;

  localparam int NCH = 4;
  localparam int DW  = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          last;
  } exp_t;

  logic              clk_rd = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH-1:0]    fifo_rd_en;
  logic [NCH*DW-1:0] fifo_dout;
  logic [NCH-1:0]    fifo_valid;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_ch;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              burst_done;

  logic [DW-1:0] fq [NCH][$];
  exp_t          exp_q[$];

  int errors    = 0;
  int checks    = 0;
  int issued    = 0;
  int bursts    = 0;
  int delivered = 0;

  always #5 clk_rd = ~clk_rd;

  sym_fifo_rd_sched dut (
    .clk_rd     (clk_rd),
    .rst_n      (rst_n),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .m_data     (m_data),
    .m_ch       (m_ch),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .burst_done (burst_done)
  );

  a_valid_onehot: assert property (@(posedge clk_rd) disable iff (!rst_n) $onehot0(fifo_valid));

  function automatic logic [DW-1:0] word(input int ch, input int tag, input int idx);
    return {8'(ch), 24'(tag), 32'(idx)};
  endfunction

  task automatic load(input int ch, input int tag, input int n);
    for (int i = 0; i < n; i++) fq[ch].push_back(word(ch, tag, i));
    fifo_empty[ch] = (fq[ch].size() == 0);
  endtask

  task automatic push_exp(input int ch, input int tag, input int first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = word(ch, tag, first + i);
      e.ch   = 2'(ch);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample DUT at the falling edge, then advance the FIFO models just after the rise.
  task automatic cycle();
    logic [NCH-1:0] rd;
    exp_t           e;
    @(negedge clk_rd);
    rd = fifo_rd_en;
    checks++;
    if (!$onehot0(rd) || ((rd & fifo_empty) != '0)) begin
      errors++;
      $display("FAIL rd_en_protocol: rd_en=%b empty=%b, required one-hot to a non-empty FIFO",
               rd, fifo_empty);
    end
    issued += $countones(rd);
    if (burst_done) bursts++;
    if (m_valid && m_ready) begin
      delivered++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: data=%h ch=%0d last=%0d, required no output",
                 m_data, m_ch, m_last);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.data || m_ch !== e.ch || m_last !== e.last) begin
          errors++;
          $display("FAIL stream_word: data=%h ch=%0d last=%0d, required data=%h ch=%0d last=%0d",
                   m_data, m_ch, m_last, e.data, e.ch, e.last);
        end
      end
    end
    @(posedge clk_rd);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (rd[k] && fq[k].size() > 0) begin
        fifo_dout[k*DW +: DW] = fq[k].pop_front();
        fifo_valid[k]         = 1'b1;
      end else begin
        fifo_valid[k] = 1'b0;
      end
      fifo_empty[k] = (fq[k].size() == 0);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    ch_mask = '1;
    m_ready = 1'b1;
    for (int k = 0; k < NCH; k++) fq[k].delete();
    fifo_empty = '1;
    fifo_valid = '0;
    fifo_dout  = '0;
    exp_q.delete();
    repeat (2) @(posedge clk_rd);
    @(negedge clk_rd);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    if (fifo_rd_en !== '0)  begin errors++; $display("FAIL reset_rd_en: %b, required 0", fifo_rd_en); end
    if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid: %b, required 0", m_valid); end
    if (m_data !== '0)      begin errors++; $display("FAIL reset_m_data: %h, required 0", m_data); end
    if (m_ch !== '0)        begin errors++; $display("FAIL reset_m_ch: %0d, required 0", m_ch); end
    if (m_last !== 1'b0)    begin errors++; $display("FAIL reset_m_last: %b, required 0", m_last); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
    if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_burst_done: %b, required 0", burst_done); end
    checks += 7;
  endtask

  task automatic test_single_ch();
    load(2, 1, 20);
    push_exp(2, 1, 0, 16);
    push_exp(2, 1, 16, 4);
    bursts = 0;
    enable = 1'b1;
    drain(300, "single_ch");
    checks++;
    if (bursts !== 2) begin errors++; $display("FAIL single_ch_bursts: %0d, required 2", bursts); end
    enable = 1'b0;
    repeat (5) cycle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_ch_idle_busy: %b, required 0", busy); end
  endtask

  task automatic test_all_ch();
    apply_reset();
    for (int k = 0; k < NCH; k++) load(k, 2, 3);
    for (int k = 0; k < NCH; k++) push_exp(k, 2, 0, 3);
    bursts = 0;
    enable = 1'b1;
    drain(300, "all_ch");
    checks++;
    if (bursts !== 4) begin errors++; $display("FAIL all_ch_bursts: %0d, required 4", bursts); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    issued  = 0;
    load(1, 3, 16);
    push_exp(1, 3, 0, 16);
    repeat (50) cycle();
    checks += 3;
    if (issued !== 4) begin errors++; $display("FAIL stall_issued: %0d, required 4", issued); end
    if (m_valid !== 1'b1 || m_data !== exp_q[0].data) begin
      errors++;
      $display("FAIL stall_head: valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, exp_q[0].data);
    end
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: %b, required 1", busy); end
    m_ready = 1'b1;
    drain(300, "backpressure");
    checks++;
    if (issued !== 16) begin errors++; $display("FAIL stall_total_issued: %0d, required 16", issued); end
  endtask

  task automatic test_enable_drop();
    int n;
    load(0, 4, 16);
    push_exp(0, 4, 0, 16);
    bursts    = 0;
    delivered = 0;
    enable    = 1'b1;
    n = 0;
    while (delivered < 5 && n < 100) begin
      cycle();
      n++;
    end
    enable = 1'b0;
    drain(300, "enable_drop");
    repeat (6) cycle();
    checks += 3;
    if (bursts !== 1) begin errors++; $display("FAIL enable_drop_bursts: %0d, required 1", bursts); end
    if (busy !== 1'b0) begin errors++; $display("FAIL enable_drop_busy: %b, required 0", busy); end
    if (fifo_rd_en !== '0) begin errors++; $display("FAIL enable_drop_rd_en: %b, required 0", fifo_rd_en); end
  endtask

  task automatic test_mask();
    ch_mask = 4'b1010;
    for (int k = 0; k < NCH; k++) load(k, 5, 20);
    push_exp(1, 5, 0, 16);
    push_exp(3, 5, 0, 16);
    push_exp(1, 5, 16, 4);
    push_exp(3, 5, 16, 4);
    enable = 1'b1;
    drain(500, "mask");
    enable = 1'b0;
    repeat (5) cycle();
    checks += 2;
    if (fq[0].size() !== 20) begin errors++; $display("FAIL mask_ch0_untouched: %0d words, required 20", fq[0].size()); end
    if (fq[2].size() !== 20) begin errors++; $display("FAIL mask_ch2_untouched: %0d words, required 20", fq[2].size()); end
  endtask

  task automatic test_reset_mid_burst();
    int   n;
    int   n2;
    exp_t e;
    for (int k = 0; k < NCH; k++) fq[k].delete();
    fifo_empty = '1;
    ch_mask    = '1;
    m_ready    = 1'b1;
    load(2, 6, 10);
    push_exp(2, 6, 0, 10);
    delivered = 0;
    enable    = 1'b1;
    n = 0;
    while (delivered < 3 && n < 100) begin
      cycle();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (fifo_rd_en !== '0)   begin errors++; $display("FAIL rst_mid_rd_en: %b, required 0", fifo_rd_en); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_mid_m_valid: %b, required 0", m_valid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: %b, required 0", busy); end
    if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_mid_burst_done: %b, required 0", burst_done); end
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    load(0, 7, 2);
    load(1, 7, 2);
    load(3, 7, 2);
    push_exp(0, 7, 0, 2);
    push_exp(1, 7, 0, 2);
    n2 = fq[2].size();
    for (int i = 0; i < n2; i++) begin
      e.data = fq[2][i];
      e.ch   = 2'd2;
      e.last = (i == n2 - 1);
      exp_q.push_back(e);
    end
    push_exp(3, 7, 0, 2);
    drain(400, "reset_mid_burst");
    enable = 1'b0;
    repeat (5) cycle();
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    ch_mask    = '1;
    m_ready    = 1'b1;
    fifo_empty = '1;
    fifo_valid = '0;
    fifo_dout  = '0;
    test_reset();
    test_single_ch();
    test_all_ch();
    test_backpressure();
    test_enable_drop();
    test_mask();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
